// File: rtl/psk_acq_sweep_ctl.sv
// psk_acq_sweep_ctl: sweeps the NCO offset, dwells on one metric window per code and locks on the strongest.
// Define PSK_ACQ_RELOCK_EN to watch metrics while locked and auto-restart after LOSS_CNT weak windows.
module psk_acq_sweep_ctl #(
    parameter int OFS_W    = 5,
    parameter int MET_W    = 8,
    parameter int SKIP     = 1,
    parameter int DWELL_TO = 65535,
    parameter int THRESH   = 40,
    parameter int LOSS_CNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             m_valid,
    input  logic [MET_W-1:0] m_value,
    output logic [OFS_W-1:0] offset,
    output logic             corr_clr,
    output logic             busy,
    output logic             locked,
    output logic             fail,
    output logic             done,
    output logic [OFS_W-1:0] best_offset,
    output logic [MET_W-1:0] best_metric
);
    typedef enum logic [2:0] {IDLE, CLEAR, DWELL, COMPARE, STEP, LOCK} state_t;

    state_t           state_q, state_d;
    logic [OFS_W-1:0] offset_q, offset_d, best_offset_q, best_offset_d;
    logic [MET_W-1:0] best_metric_q, best_metric_d, sample_q, sample_d;
    logic [15:0]      timer_q, timer_d;
    logic [7:0]       skip_q, skip_d;
    logic             busy_q, busy_d, locked_q, locked_d, fail_q, fail_d;
    logic             done_q, done_d, corr_clr_q, corr_clr_d, blocked_q, blocked_d;
    logic             trig, accept, timeout, last, lock_ok, lost;

    // start only fires once it has been seen low since the previous trigger
    assign trig    = start && !blocked_q && !abort && (state_q == IDLE || state_q == LOCK);
    assign accept  = m_valid && skip_q == 8'(SKIP);
    assign timeout = timer_q == 16'(DWELL_TO - 1);
    assign last    = offset_q == '1;
    assign lock_ok = best_metric_q >= MET_W'(THRESH);

`ifdef PSK_ACQ_RELOCK_EN
    logic [7:0] loss_q, loss_d;

    assign lost = !abort && state_q == LOCK && m_valid && m_value < MET_W'(THRESH)
                  && loss_q == 8'(LOSS_CNT - 1);

    always_comb begin
        loss_d = loss_q;
        if (state_q != LOCK || abort || trig || lost)
            loss_d = '0;
        else if (m_valid)
            loss_d = m_value < MET_W'(THRESH) ? loss_q + 8'd1 : '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) loss_q <= '0;
        else        loss_q <= loss_d;
`else
    assign lost = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            offset_q      <= '0;
            best_offset_q <= '0;
            best_metric_q <= '0;
            sample_q      <= '0;
            timer_q       <= '0;
            skip_q        <= '0;
            busy_q        <= 1'b0;
            locked_q      <= 1'b0;
            fail_q        <= 1'b0;
            done_q        <= 1'b0;
            corr_clr_q    <= 1'b0;
            blocked_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            offset_q      <= offset_d;
            best_offset_q <= best_offset_d;
            best_metric_q <= best_metric_d;
            sample_q      <= sample_d;
            timer_q       <= timer_d;
            skip_q        <= skip_d;
            busy_q        <= busy_d;
            locked_q      <= locked_d;
            fail_q        <= fail_d;
            done_q        <= done_d;
            corr_clr_q    <= corr_clr_d;
            blocked_q     <= blocked_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort)
            state_d = IDLE;
        else if (trig || lost)
            state_d = CLEAR;
        else
            case (state_q)
                CLEAR:   state_d = DWELL;
                DWELL:   state_d = (accept || timeout) ? COMPARE : DWELL;
                COMPARE: state_d = STEP;
                STEP:    state_d = !last ? CLEAR : lock_ok ? LOCK : IDLE;
                default: state_d = state_q;
            endcase
    end

    always_comb begin
        offset_d      = offset_q;
        best_offset_d = best_offset_q;
        best_metric_d = best_metric_q;
        sample_d      = sample_q;
        timer_d       = timer_q;
        skip_d        = skip_q;
        busy_d        = busy_q;
        locked_d      = locked_q;
        fail_d        = fail_q;
        done_d        = 1'b0;
        corr_clr_d    = state_d == CLEAR;
        blocked_d     = start && (blocked_q || trig);
        if (abort) begin
            busy_d   = 1'b0;
            locked_d = 1'b0;
        end else if (trig || lost) begin
            offset_d      = '0;
            best_offset_d = '0;
            best_metric_d = '0;
            fail_d        = 1'b0;
            locked_d      = 1'b0;
            busy_d        = 1'b1;
        end else
            case (state_q)
                CLEAR: begin
                    timer_d = '0;
                    skip_d  = '0;
                end
                DWELL: begin
                    timer_d = timer_q + 16'd1;
                    if (accept)
                        sample_d = m_value;
                    else if (timeout)
                        sample_d = '0;
                    else if (m_valid)
                        skip_d = skip_q + 8'd1;
                end
                COMPARE: begin
                    // strict compare keeps the lowest offset on ties
                    if (sample_q > best_metric_q) begin
                        best_metric_d = sample_q;
                        best_offset_d = offset_q;
                    end
                end
                STEP: begin
                    if (!last)
                        offset_d = offset_q + 1'b1;
                    else if (lock_ok) begin
                        offset_d = best_offset_q;
                        locked_d = 1'b1;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        offset_d = '0;
                        fail_d   = 1'b1;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end
                end
                default: ;
            endcase
    end

    assign offset      = offset_q;
    assign corr_clr    = corr_clr_q;
    assign busy        = busy_q;
    assign locked      = locked_q;
    assign fail        = fail_q;
    assign done        = done_q;
    assign best_offset = best_offset_q;
    assign best_metric = best_metric_q;
endmodule

// File: tb/tb_psk_acq_sweep_ctl.sv
// tb_psk_acq_sweep_ctl: plans each sweep as a timeline of per-cycle inputs and expected outputs, then replays it.
module tb_psk_acq_sweep_ctl;
    localparam int OFS_W = 5, MET_W = 8, SKIP = 1, DWELL_TO = 100, THRESH = 40, NOFS = 32;

    logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, m_valid = 1'b0;
    logic [MET_W-1:0] m_value = '0;
    logic [OFS_W-1:0] offset, best_offset;
    logic [MET_W-1:0] best_metric;
    logic             corr_clr, busy, locked, fail, done;

    psk_acq_sweep_ctl #(.OFS_W(OFS_W), .MET_W(MET_W), .SKIP(SKIP), .DWELL_TO(DWELL_TO),
                        .THRESH(THRESH), .LOSS_CNT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .m_valid(m_valid),
        .m_value(m_value), .offset(offset), .corr_clr(corr_clr), .busy(busy), .locked(locked),
        .fail(fail), .done(done), .best_offset(best_offset), .best_metric(best_metric));

    always #5 clk = ~clk;

    typedef struct packed {logic st; logic ab; logic mv; logic [7:0] val;} in_t;
    typedef struct packed {logic [4:0] ofs; logic [4:0] bofs; logic [7:0] bmet;
                           logic clr; logic bsy; logic lk; logic fl; logic dn;} out_t;

    in_t  vin[$];
    out_t vexp[$];
    out_t o = '0;
    int   checks = 0, errors = 0, n_clr = 0, n_done = 0;
    logic [7:0] met [NOFS];

    function automatic logic [7:0] r8();
        return 8'($urandom);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // one planned clock: inputs for the edge and the outputs expected right after it
    task automatic step(input logic st, input logic ab, input logic mv, input logic [7:0] v);
        in_t x;
        x.st = st; x.ab = ab; x.mv = mv; x.val = v;
        vin.push_back(x);
        vexp.push_back(o);
        o.clr = 1'b0;
        o.dn  = 1'b0;
    endtask

    task automatic idle(input int n, input logic st);
        for (int i = 0; i < n; i++) step(st, 1'b0, rb(), r8());
    endtask

    task automatic sweep(input int miss, input int late, input int ab_ofs, input int ab_pos, input logic hold);
        o.ofs = '0; o.bofs = '0; o.bmet = '0; o.clr = 1'b1; o.bsy = 1'b1; o.lk = 1'b0; o.fl = 1'b0;
        step(1'b1, 1'b0, rb(), r8());
        for (int k = 0; k < NOFS; k++) begin
            in_t        dw[$];
            in_t        x;
            logic [7:0] eff;
            step(hold, 1'b0, rb(), r8());
            x.st = hold; x.ab = 1'b0;
            if (k == miss) begin
                eff = 8'd0;
                for (int j = 0; j < DWELL_TO; j++) begin
                    x.mv = 1'b0; x.val = r8(); dw.push_back(x);
                end
                if (rb()) dw[$urandom_range(0, DWELL_TO - 2)].mv = 1'b1;
            end else begin
                eff = met[k];
                for (int s = 0; s <= SKIP; s++) begin
                    int gap;
                    gap = (k == late && s == SKIP) ? DWELL_TO - 1 - dw.size() : $urandom_range(0, 3);
                    for (int g = 0; g < gap; g++) begin
                        x.mv = 1'b0; x.val = r8(); dw.push_back(x);
                    end
                    x.mv = 1'b1; x.val = (s == SKIP) ? met[k] : r8(); dw.push_back(x);
                end
            end
            for (int j = 0; j < dw.size(); j++) begin
                if (k == ab_ofs && j == ab_pos) begin
                    o.bsy = 1'b0; o.lk = 1'b0;
                    step(1'b1, 1'b1, dw[j].mv, dw[j].val);
                    return;
                end
                step(dw[j].st, 1'b0, dw[j].mv, dw[j].val);
            end
            if (eff > o.bmet) begin
                o.bmet = eff; o.bofs = 5'(k);
            end
            step(hold, 1'b0, rb(), r8());
            if (k < NOFS - 1) begin
                o.ofs = 5'(k + 1); o.clr = 1'b1;
            end else begin
                if (o.bmet >= THRESH) begin
                    o.ofs = o.bofs; o.lk = 1'b1;
                end else begin
                    o.ofs = '0; o.fl = 1'b1;
                end
                o.bsy = 1'b0; o.dn = 1'b1;
            end
            step(hold, 1'b0, rb(), r8());
        end
    endtask

    // the single compare process: replays the plan and checks every cycle
    task automatic run();
        out_t act;
        n_clr = 0; n_done = 0;
        for (int i = 0; i < vin.size(); i++) begin
            @(negedge clk);
            start = vin[i].st; abort = vin[i].ab; m_valid = vin[i].mv; m_value = vin[i].val;
            @(posedge clk);
            #1;
            act = {offset, best_offset, best_metric, corr_clr, busy, locked, fail, done};
            n_clr += int'(corr_clr);
            n_done += int'(done);
            checks++;
            if (act !== vexp[i]) begin
                errors++;
                $display("FAIL cycle %0d: got ofs=%0d bofs=%0d bmet=%0d clr=%b busy=%b lk=%b fail=%b done=%b, expected ofs=%0d bofs=%0d bmet=%0d clr=%b busy=%b lk=%b fail=%b done=%b",
                         i, act.ofs, act.bofs, act.bmet, act.clr, act.bsy, act.lk, act.fl, act.dn,
                         vexp[i].ofs, vexp[i].bofs, vexp[i].bmet, vexp[i].clr, vexp[i].bsy,
                         vexp[i].lk, vexp[i].fl, vexp[i].dn);
            end
        end
        vin.delete();
        vexp.delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", int'({offset, best_offset, best_metric, corr_clr, busy, locked, fail, done}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single strong peak at offset 13
        for (int k = 0; k < NOFS; k++) met[k] = (k == 13) ? 8'd200 : 8'd10;
        idle(2, 1'b0); sweep(-1, -1, -1, -1, 1'b0); idle(4, 1'b0);
        run();
        chk("peak_clr_pulses", n_clr, 32);
        chk("peak_done_pulses", n_done, 1);
        chk("peak_locked", int'(locked), 1);
        chk("peak_offset", int'(offset), 13);
        chk("peak_best_offset", int'(best_offset), 13);
        chk("peak_best_metric", int'(best_metric), 200);
        chk("peak_fail", int'(fail), 0);

        // abort while locked keeps offset
        o.lk = 1'b0;
        step(1'b0, 1'b1, rb(), r8()); idle(2, 1'b0);
        run();
        chk("lock_abort_locked", int'(locked), 0);
        chk("lock_abort_offset", int'(offset), 13);

        // everything below threshold
        for (int k = 0; k < NOFS; k++) met[k] = 8'd30;
        sweep(-1, -1, -1, -1, 1'b0); idle(2, 1'b0);
        step(1'b1, 1'b1, rb(), r8()); idle(2, 1'b0);
        run();
        chk("weak_fail", int'(fail), 1);
        chk("weak_locked", int'(locked), 0);
        chk("weak_offset", int'(offset), 0);
        chk("weak_best_metric", int'(best_metric), 30);
        chk("weak_best_offset", int'(best_offset), 0);
        chk("weak_done_pulses", n_done, 1);

        // tie between offsets 5 and 20
        for (int k = 0; k < NOFS; k++) met[k] = (k == 5 || k == 20) ? 8'd90 : 8'd0;
        sweep(-1, -1, -1, -1, 1'b0); idle(3, 1'b0);
        run();
        chk("tie_best_offset", int'(best_offset), 5);
        chk("tie_locked", int'(locked), 1);

        // offset 7 times out, offset 3 accepted on the timeout cycle
        for (int k = 0; k < NOFS; k++) met[k] = (k == 7) ? 8'd250 : (k == 3) ? 8'd60 : 8'd20;
        sweep(7, 3, -1, -1, 1'b0); idle(3, 1'b0);
        run();
        chk("to_best_offset", int'(best_offset), 3);
        chk("to_best_metric", int'(best_metric), 60);

        // abort mid-dwell at offset 9, then a held-start sweep
        for (int k = 0; k < NOFS; k++) met[k] = r8();
        sweep(-1, -1, 9, 1, 1'b0); idle(3, 1'b0);
        run();
        chk("abort_busy", int'(busy), 0);
        chk("abort_offset", int'(offset), 9);
        chk("abort_done_pulses", n_done, 0);
        for (int k = 0; k < NOFS; k++) met[k] = r8();
        sweep(-1, -1, -1, -1, 1'b1); idle(6, 1'b1); idle(2, 1'b0);
        run();
        chk("hold_done_pulses", n_done, 1);

        for (int r = 0; r < 6; r++) begin
            logic lo;
            lo = rb();
            for (int k = 0; k < NOFS; k++) met[k] = lo ? 8'($urandom_range(0, THRESH - 1)) : r8();
            sweep(rb() ? int'($urandom_range(0, NOFS - 1)) : -1, rb() ? int'($urandom_range(0, NOFS - 1)) : -1,
                  -1, -1, rb());
            idle($urandom_range(1, 4), 1'b0);
        end
        run();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
